// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimator best-match stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package me_pkg;

  localparam int DIST_W_DEF = 8;
  localparam int MV_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } mv_t;

  // Raster order: x runs fastest, y advances every 2**mv_w candidates.
  function automatic mv_t cand_to_mv(input logic [31:0] k, input int mv_w);
    mv_t         mv;
    logic [31:0] mask;
    mask = (32'd1 << mv_w) - 32'd1;
    mv.x = 16'(k & mask);
    mv.y = 16'(k >> mv_w);
    return mv;
  endfunction

endpackage

// File: rtl/best_match_comparator_if.sv
// Distance stream in / best-match result out between PE array, comparator and frame controller.
// Latency: n/a (wires only).
// Backpressure: none; the producer owns dist_valid and the consumer always accepts.
interface best_match_comparator_if
  import me_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int MV_W   = MV_W_DEF
);

  logic              start;
  logic              dist_valid;
  logic [DIST_W-1:0] dist_in;
  logic [DIST_W-1:0] best_dist;
  logic [MV_W-1:0]   motion_x;
  logic [MV_W-1:0]   motion_y;
  logic              busy;
  logic              done;

  modport master (
    output start, dist_valid, dist_in,
    input  best_dist, motion_x, motion_y, busy, done
  );

  modport slave (
    input  start, dist_valid, dist_in,
    output best_dist, motion_x, motion_y, busy, done
  );

endinterface

// File: rtl/best_match_comparator.sv
// Tracks the minimum SAD and its motion vector over one search window of NUM_CAND candidates.
// Latency: 1 cycle from an accepted sample to updated outputs; done pulses 1 cycle after the last sample.
// Backpressure: none; every dist_valid cycle in SCAN is consumed, idle cycles simply stall the count.
module best_match_comparator
  import me_pkg::*;
#(
  parameter int DIST_W   = DIST_W_DEF,
  parameter int MV_W     = MV_W_DEF,
  parameter int NUM_CAND = 2 ** (2 * MV_W)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  best_match_comparator_if.slave  bus
);

  localparam int             CNT_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CAND - 1);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cand_cnt;
  logic              launch;
  logic              accept;
  logic              last;
  logic              take;

  // A new search can only be launched from IDLE or DONE; start in SCAN is ignored.
  assign launch = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept = bus.dist_valid && (state_q == ST_SCAN);
  assign last   = (cand_cnt == LAST_IDX);
  // First candidate always loads so an all-ones distance still records mv (0,0); ties keep the earlier one.
  assign take   = accept && ((cand_cnt == '0) || (bus.dist_in < bus.best_dist));

  assign bus.busy = (state_q == ST_SCAN);
  assign bus.done = (state_q == ST_DONE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE is a single cycle unless a new start chains straight into SCAN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_SCAN;
      ST_SCAN: if (accept && last) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_SCAN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Candidate counter and best-so-far registers; results hold outside SCAN until the next launch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand_cnt      <= '0;
      bus.best_dist <= '1;
      bus.motion_x  <= '0;
      bus.motion_y  <= '0;
    end else if (launch) begin
      cand_cnt      <= '0;
      bus.best_dist <= '1;
      bus.motion_x  <= '0;
      bus.motion_y  <= '0;
    end else if (accept) begin
      // Hold at the last index rather than wrapping; the next launch clears it.
      if (!last) begin
        cand_cnt <= cand_cnt + 1'b1;
      end
      if (take) begin
        bus.best_dist <= bus.dist_in;
        bus.motion_x  <= MV_W'(cand_to_mv(32'(cand_cnt), MV_W).x);
        bus.motion_y  <= MV_W'(cand_to_mv(32'(cand_cnt), MV_W).y);
      end
    end
  end

endmodule

// File: tb/tb_best_match_comparator.sv
// Self-checking bench for best_match_comparator with a 2x2 search window.
// Latency: n/a.
// Backpressure: n/a.
module tb_best_match_comparator;

  localparam int DIST_W   = 8;
  localparam int MV_W     = 1;
  localparam int NUM_CAND = 4;
  localparam int ALL_ONES = (1 << DIST_W) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  best_match_comparator_if #(.DIST_W(DIST_W), .MV_W(MV_W)) bus_if ();

  best_match_comparator #(
    .DIST_W  (DIST_W),
    .MV_W    (MV_W),
    .NUM_CAND(NUM_CAND)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0=idle, 1=scanning, 2=done; q holds the samples accepted this search.
  int m_phase = 0;
  int q[$];

  task automatic model_reset();
    m_phase = 0;
    q.delete();
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else begin
      case (m_phase)
        1: begin
          if (bus_if.dist_valid) begin
            q.push_back(int'(bus_if.dist_in));
            if (q.size() == NUM_CAND) m_phase = 2;
          end
        end
        default: begin
          if (bus_if.start) begin
            m_phase = 1;
            q.delete();
          end else begin
            m_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Compares every output against the minimum of the accepted samples (first minimum wins).
  task automatic check_all(input string tag);
    int bd;
    int idx;
    bd  = ALL_ONES;
    idx = 0;
    foreach (q[i]) begin
      if (i == 0 || q[i] < bd) begin
        bd  = q[i];
        idx = i;
      end
    end
    check({tag, ".best"}, 32'(bus_if.best_dist), 32'(bd));
    check({tag, ".mx"},   32'(bus_if.motion_x),  32'(idx % (1 << MV_W)));
    check({tag, ".my"},   32'(bus_if.motion_y),  32'(idx / (1 << MV_W)));
    check({tag, ".busy"}, 32'(bus_if.busy),      32'(m_phase == 1));
    check({tag, ".done"}, 32'(bus_if.done),      32'(m_phase == 2));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  // Launches a search with a concurrent sample that must not be accepted.
  task automatic start_search(input string tag);
    bus_if.start      = 1'b1;
    bus_if.dist_valid = 1'b1;
    bus_if.dist_in    = '0;
    tick();
    bus_if.start      = 1'b0;
    bus_if.dist_valid = 1'b0;
    check_all({tag, ".start"});
  endtask

  // Optional stall cycles (optionally with start poked) before one accepted sample.
  task automatic feed(input int v, input int gap, input bit poke, input string tag);
    for (int g = 0; g < gap; g++) begin
      bus_if.dist_valid = 1'b0;
      bus_if.start      = poke;
      tick();
      bus_if.start = 1'b0;
      check_all({tag, ".gap"});
    end
    bus_if.dist_valid = 1'b1;
    bus_if.dist_in    = DIST_W'(v);
    tick();
    bus_if.dist_valid = 1'b0;
    check_all({tag, ".smp"});
  endtask

  initial begin
    bus_if.start      = 1'b0;
    bus_if.dist_valid = 1'b0;
    bus_if.dist_in    = '0;
    model_reset();

    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    #1 check_all("por");
    tick();
    check_all("rst_hold");
    reset_n = 1'b1;
    tick();
    check_all("idle");

    // A zero-valued sample in IDLE is ignored.
    bus_if.dist_valid = 1'b1;
    bus_if.dist_in    = '0;
    tick();
    bus_if.dist_valid = 1'b0;
    check_all("idle_dv");
    check("idle_dv.const", 32'(bus_if.best_dist), 32'hFF);

    // Monotonically decreasing distances.
    start_search("mono");
    feed(9, 0, 1'b0, "mono");
    feed(7, 0, 1'b0, "mono");
    feed(5, 0, 1'b0, "mono");
    feed(3, 0, 1'b0, "mono");
    check("mono.best_c", 32'(bus_if.best_dist), 32'd3);
    check("mono.mv_c",   {30'd0, bus_if.motion_y, bus_if.motion_x}, 32'd3);
    check("mono.done_c", 32'(bus_if.done), 32'd1);
    tick();
    check_all("mono.after");

    // Ties keep the first minimum; stalls and mid-scan start are harmless.
    start_search("tie");
    feed(6, 0, 1'b0, "tie");
    feed(2, 2, 1'b1, "tie");
    feed(2, 1, 1'b0, "tie");
    feed(8, 3, 1'b1, "tie");
    check("tie.best_c", 32'(bus_if.best_dist), 32'd2);
    check("tie.mx_c",   32'(bus_if.motion_x),  32'd1);
    check("tie.my_c",   32'(bus_if.motion_y),  32'd0);
    tick();
    check_all("tie.after");

    // All-ones first sample still loads; then start straight from DONE.
    start_search("ones");
    for (int i = 0; i < NUM_CAND; i++) feed(255, 0, 1'b0, "ones");
    check("ones.best_c", 32'(bus_if.best_dist), 32'd255);
    check("ones.mv_c",   {30'd0, bus_if.motion_y, bus_if.motion_x}, 32'd0);
    check("ones.done_c", 32'(bus_if.done), 32'd1);
    start_search("b2b");
    check("b2b.busy_c", 32'(bus_if.busy), 32'd1);
    feed(4, 0, 1'b0, "b2b");
    feed(1, 0, 1'b0, "b2b");
    feed(9, 1, 1'b0, "b2b");
    feed(1, 0, 1'b0, "b2b");
    check("b2b.best_c", 32'(bus_if.best_dist), 32'd1);
    check("b2b.mx_c",   32'(bus_if.motion_x),  32'd1);
    tick();
    check_all("b2b.after");

    // Reset in the middle of a search: no done pulse, fresh search works.
    start_search("mid");
    feed(2, 0, 1'b0, "mid");
    feed(5, 0, 1'b0, "mid");
    reset_n = 1'b0;
    model_reset();
    #1 check_all("mid.async");
    check("mid.best_c", 32'(bus_if.best_dist), 32'hFF);
    tick();
    check_all("mid.hold0");
    tick();
    check_all("mid.hold1");
    reset_n = 1'b1;
    tick();
    check_all("mid.rel");
    start_search("fresh");
    feed(7, 0, 1'b0, "fresh");
    feed(3, 1, 1'b0, "fresh");
    feed(3, 0, 1'b0, "fresh");
    feed(0, 2, 1'b0, "fresh");
    check("fresh.best_c", 32'(bus_if.best_dist), 32'd0);
    check("fresh.mv_c",   {30'd0, bus_if.motion_y, bus_if.motion_x}, 32'd3);
    check("fresh.done_c", 32'(bus_if.done), 32'd1);
    tick();
    check_all("fresh.after");

    // Randomized traffic with narrow distance ranges to provoke ties.
    for (int n = 0; n < 400; n++) begin
      bus_if.start      = ($urandom_range(0, 7) == 0);
      bus_if.dist_valid = ($urandom_range(0, 2) != 0);
      bus_if.dist_in    = ($urandom_range(0, 1) == 0) ? DIST_W'($urandom_range(0, 255))
                                                      : DIST_W'($urandom_range(0, 7));
      tick();
      check_all("rand");
    end
    bus_if.start      = 1'b0;
    bus_if.dist_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/best_match_comparator.md
Name: best_match_comparator

Overview:
- Downstream stage of the PE array in the motion estimator.
- Consumes one final block distance (SAD) per candidate displacement as each PE's accumulator completes.
- Tracks the minimum distance and its motion vector across one full search window.
- Presents the winning displacement to the frame controller with a one-cycle done pulse.

Parameters:
- DIST_W, 8: width of the incoming distance; matches the PE accumulator output.
- MV_W, 4: width of each motion-vector component (x, y).
- NUM_CAND, 256: candidates per search, 2**(2*MV_W) by default. Legal range is 1 to 2**(2*MV_W).

Ports:
- clock, input, 1: rising-edge system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a new search. Sampled only in IDLE or DONE.
- dist_valid, input, 1: dist_in holds a completed candidate distance this cycle.
- dist_in, input, DIST_W: candidate distance from the PE array.
- best_dist, output, DIST_W: minimum distance found so far / final result.
- motion_x, output, MV_W: x displacement of best_dist.
- motion_y, output, MV_W: y displacement of best_dist.
- busy, output, 1: high while in SCAN.
- done, output, 1: single-cycle pulse when the search completes.

Behaviour:
- Reset: asynchronous, active-low. Clock is clock; reset is reset_n.
- Reset values: state=IDLE, cand_cnt=0, best_dist=all ones, motion_x=0, motion_y=0, busy=0, done=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on start=1. At the same edge: cand_cnt=0, best_dist=all ones, motion_x=0, motion_y=0.
- SCAN, accepted sample:
  - Each cycle with dist_valid=1 accepts one sample.
  - Candidate index k = cand_cnt.
  - Raster mapping: x = k mod 2**MV_W, y = k / 2**MV_W.
- SCAN, update rule:
  - The first accepted sample (k=0) loads best_dist, motion_x and motion_y unconditionally, even if it equals all ones.
  - A later sample updates them only if dist_in < best_dist (strict). Ties keep the earlier candidate.
  - Outputs are registered: an update is visible the cycle after the accepting edge.
- SCAN, counting:
  - cand_cnt increments per accepted sample.
  - dist_valid=0 cycles stall. There is no timeout.
- SCAN -> DONE:
  - Occurs on the edge accepting sample k=NUM_CAND-1.
  - done=1 for exactly the next cycle; busy drops in that same cycle.
- DONE:
  - best_dist, motion_x and motion_y hold until the next start.
  - DONE lasts one cycle, then returns to IDLE unless start=1, which goes directly to SCAN.
- Ignored inputs:
  - start during SCAN is ignored.
  - dist_valid in IDLE or DONE is ignored; no counting, no update.
- start and dist_valid together in IDLE: start takes effect. The concurrent sample is not accepted.
- Reset mid-SCAN: immediate return to reset values. No done pulse.
- Width rules:
  - Comparison is unsigned, DIST_W bits.
  - cand_cnt is wide enough to hold NUM_CAND-1. With the default this is 8 bits and it never wraps, because DONE is reached first.
- Latency: one cycle from the last accepted sample to done and the final outputs being valid together.

Decomposition:
- Shared package me_pkg:
  - DIST_W and MV_W defaults.
  - State enum for IDLE/SCAN/DONE.
  - Function mapping a candidate index to (x, y).
- No sub-module. The comparator, counter and FSM are small enough to live in one module.

Test Plan:
- Reset then idle: hold reset_n=0 mid-clock. Outputs go to best_dist=0xFF, mv=(0,0), busy=0, done=0 without waiting for a clock edge.
- Monotonic search, NUM_CAND=4, MV_W=1: feed 9,7,5,3 -> best_dist=3, motion=(1,1), one done pulse the cycle after the 4th sample.
- Tie handling: feed 6,2,2,8 -> best_dist=2, motion_x=1, motion_y=0 (first minimum kept).
- Stalls and ignored inputs:
  - Insert dist_valid=0 gaps between samples: result is unchanged.
  - Pulse start mid-SCAN: no restart.
  - Drive dist_valid with value 0 in IDLE: best_dist stays 0xFF.
- First-sample load and back-to-back: first sample 255 -> best_dist=255 with motion=(0,0). Then assert start in the DONE cycle -> busy=1 next cycle, and the new search's outputs are independent of the old one.
- Reset mid-search: assert reset_n=0 after 2 of 4 samples -> outputs return to reset values, no done pulse. A fresh start completes normally.
